// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, captures the combinational instruction-memory word into IF/ID.
// Optional feature macro FETCH_PERF_CNT_EN adds FetchCount/StallCount performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] RD,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pc_plus4_f;
    logic [31:0] pc_next_f;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc_plus4d_q, pc_plus4d_d;
    logic        valid_q, valid_d;
    logic        ifid_load;

    // Targets are word-aligned by construction; the wrap past 0xFFFF_FFFC is intentional.
    assign pc_plus4_f = pcf_q + 32'd4;
    assign pc_next_f  = PCSrcE ? {PCTargetE[31:2], 2'b00} : pc_plus4_f;

    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = pc_next_f;
        end else if (!StallF) begin
            pcf_d = pc_plus4_f;
        end
    end

    assign ifid_load = !FlushD && !StallD;

    always_comb begin
        instr_d     = instr_q;
        pcd_d       = pcd_q;
        pc_plus4d_d = pc_plus4d_q;
        valid_d     = valid_q;
        if (FlushD) begin
            instr_d     = NOP_INSTR;
            pcd_d       = 32'd0;
            pc_plus4d_d = 32'd0;
            valid_d     = 1'b0;
        end else if (!StallD) begin
            instr_d     = RD;
            pcd_d       = pcf_q;
            pc_plus4d_d = pc_plus4_f;
            valid_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q       <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pcd_q       <= 32'd0;
            pc_plus4d_q <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            pcf_q       <= pcf_d;
            instr_q     <= instr_d;
            pcd_q       <= pcd_d;
            pc_plus4d_q <= pc_plus4d_d;
            valid_q     <= valid_d;
        end
    end

    assign PCF      = pcf_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pc_plus4d_q;
    assign ValidD   = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // A redirecting edge is not a stall even when StallF is high.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (ifid_load) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (StallF && !PCSrcE) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-edge vectors with hand-computed expectations.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] RD;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, StallCount;
`endif

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .RD        (RD),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount(FetchCount),
        .StallCount(StallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem = 32'h0050_0093;
            32'h0000_0004: imem = 32'h00A0_0113;
            32'h0000_0008: imem = 32'h0020_81B3;
            32'h0000_000C: imem = 32'h4020_8233;
            32'h0000_0010: imem = 32'h0041_A2B3;
            32'h0000_0040: imem = 32'hFE00_0EE3;
            32'h0000_0044: imem = 32'h00C0_0393;
            default:       imem = 32'h0010_0073;
        endcase
    endfunction

    assign RD = imem(PCF);

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        v;
        logic        chk_cnt;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   row_idx   = 0;

    task automatic check32(input string name, input int row, input logic [31:0] act,
                           input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s row %0d: got %08h expected %08h", name, row, act, exp);
    endtask

    // Monitor: one expectation per active edge, sampled 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("PCF",      row_idx, PCF,      e.pcf);
                check32("InstrD",   row_idx, InstrD,   e.instr);
                check32("PCD",      row_idx, PCD,      e.pcd);
                check32("PCPlus4D", row_idx, PCPlus4D, e.p4);
                check32("ValidD",   row_idx, {31'd0, ValidD}, {31'd0, e.v});
`ifdef FETCH_PERF_CNT_EN
                if (e.chk_cnt) begin
                    check32("FetchCount", row_idx, FetchCount, e.fc);
                    check32("StallCount", row_idx, StallCount, e.sc);
                end
`endif
                row_idx++;
            end
        end
    end

    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tgt,
                        input logic [31:0] e_pcf, input logic [31:0] e_instr,
                        input logic [31:0] e_pcd, input logic [31:0] e_p4, input logic e_v,
                        input logic chk = 1'b0, input logic [31:0] fc = 32'd0,
                        input logic [31:0] sc = 32'd0);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fd;
        PCSrcE    = ps;
        PCTargetE = tgt;
        e.pcf = e_pcf; e.instr = e_instr; e.pcd = e_pcd; e.p4 = e_p4; e.v = e_v;
        e.chk_cnt = chk; e.fc = fc; e.sc = sc;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'd0;
        //    rst sf sd fd ps target          PCF            InstrD         PCD            PCPlus4D       V
        step(1, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0000_0013, 32'h0,         32'h0,         0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_0004, 32'h0050_0093, 32'h0,         32'h4,         1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_0008, 32'h00A0_0113, 32'h4,         32'h8,         1);
        step(0, 1, 1, 0, 0, 32'h0,         32'h0000_0008, 32'h00A0_0113, 32'h4,         32'h8,         1);
        step(0, 1, 1, 0, 0, 32'h0,         32'h0000_0008, 32'h00A0_0113, 32'h4,         32'h8,         1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_000C, 32'h0020_81B3, 32'h8,         32'hC,         1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_0010, 32'h4020_8233, 32'hC,         32'h10,        1);
        step(0, 0, 0, 1, 1, 32'h40,        32'h0000_0040, 32'h0000_0013, 32'h0,         32'h0,         0);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_0044, 32'hFE00_0EE3, 32'h40,        32'h44,        1);
        step(0, 1, 0, 0, 1, 32'h43,        32'h0000_0040, 32'h00C0_0393, 32'h44,        32'h48,        1);
        step(0, 1, 0, 0, 0, 32'h0,         32'h0000_0040, 32'hFE00_0EE3, 32'h40,        32'h44,        1);
        step(0, 0, 1, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFE00_0EE3, 32'h40,        32'h44,        1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0010_0073, 32'hFFFF_FFFC, 32'h0,         1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_0004, 32'h0050_0093, 32'h0,         32'h4,         1);
        step(0, 0, 1, 1, 0, 32'h0,         32'h0000_0008, 32'h0000_0013, 32'h0,         32'h0,         0);
        step(1, 1, 0, 0, 1, 32'h80,        32'h0000_0000, 32'h0000_0013, 32'h0,         32'h0,         0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 32'h0,         32'h0000_0004, 32'h0000_0013, 32'h0,         32'h0,         0);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_0008, 32'h00A0_0113, 32'h4,         32'h8,         1);
        step(0, 1, 1, 0, 0, 32'h0,         32'h0000_0008, 32'h00A0_0113, 32'h4,         32'h8,         1);
        step(0, 1, 0, 0, 0, 32'h0,         32'h0000_0008, 32'h0020_81B3, 32'h8,         32'hC,         1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h0000_000C, 32'h0020_81B3, 32'h8,         32'hC,         1, 1, 3, 2);
        @(negedge clk);
        StallF = 1'b0; StallD = 1'b0; PCSrcE = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: run exceeded 5000 time units, required completion");
        $fatal(1, "timeout");
    end

endmodule
